conv_window_accumulator: RTL and testbench
==========================================

// Module: conv_window_accumulator
// PURPOSE
//   Downstream consumer of Booth_Multiplier: accumulates one convolution window of signed
//   2*SIZE-bit products plus a per-filter bias, then rounds and saturates to SIZE-bit fixed point.
//   Sits between the multiplier array and the feature-map write-back in the CNN datapath.
// PARAMETERS
//   SIZE        16  operand width; products are 2*SIZE bits, result is SIZE bits (signed Q.FRAC_BITS)
//   FRAC_BITS    8  fractional bits of operands/bias/result; products carry 2*FRAC_BITS
//   KERNEL_TAPS 25  products per window (5x5); legal range 1..255
//   ACC_W       40  accumulator width; must be >= 2*SIZE+$clog2(KERNEL_TAPS)+2 (elaboration $error)
// PORTS
//   clk         in   1        single clock, rising edge
//   rst         in   1        synchronous, active-high reset
//   bias_i      in   SIZE     signed filter bias; sampled only with the first tap of a window
//   prod_i      in   2*SIZE   signed product from Booth_Multiplier
//   prod_valid  in   1        prod_i/bias_i valid
//   prod_ready  out  1        block accepts a product this cycle
//   out_data    out  SIZE     rounded, saturated window result
//   out_valid   out  1        out_data valid
//   out_ready   in   1        downstream accepts out_data
//   busy        out  1        high whenever state != IDLE
// BEHAVIOUR
//   Reset: state=IDLE, acc=0, tap_cnt=0, out_data=0, out_valid=0; prod_ready=1 next cycle.
//   Transfer occurs only on valid&&ready same edge; prod_valid may drop between taps (bubbles OK).
//   FSM IDLE: prod_ready=1; on accept acc<=(sext(bias_i)<<<FRAC_BITS)+sext(prod_i), tap_cnt<=1;
//     -> ROUND if KERNEL_TAPS==1 else ACCUM.
//   ACCUM: prod_ready=1; on accept acc<=acc+sext(prod_i), tap_cnt++; accept of tap KERNEL_TAPS -> ROUND.
//   ROUND (1 cycle): prod_ready=0; out_data<=sat(round(acc)); out_valid<=1; -> HOLD.
//   HOLD: prod_ready=0; out_valid, out_data held stable until out_ready; on handshake out_valid<=0 -> IDLE.
//   Latency: last tap accepted at edge N -> out_valid high after edge N+1; next window
//     accepted no earlier than the edge after the output handshake.
//   round(): r=(acc+(1<<<(FRAC_BITS-1)))>>>FRAC_BITS (round half toward +inf); FRAC_BITS=0 -> no add.
//   sat(): clamp r to [-2^(SIZE-1), 2^(SIZE-1)-1]; no wrap-around ever visible on out_data.
//   acc never overflows given the ACC_W rule; intermediate sums are not saturated.
//   prod_valid in ROUND/HOLD is ignored (not consumed); upstream must hold it.
//   rst mid-window or in HOLD: partial sum and pending output discarded, IDLE next cycle.
// CONFIGURATION
//   CONV_WINDOW_ACC_RELU_EN defined: sat() result passed through ReLU (negative -> 0) before out_data.
//   Undefined: signed saturated result output unchanged.
// STRUCTURE
//   Shared package cnn_pkg: typedef enum logic[1:0] {IDLE,ACCUM,ROUND,HOLD} acc_state_t;
//     localparams for SIZE/FRAC_BITS defaults shared with Booth_Multiplier instances.
//   Sub-module acc_round_sat (combinational: ACC_W in -> SIZE out, round+saturate+optional ReLU).
// TESTING (SIZE=16, FRAC_BITS=8, KERNEL_TAPS=25)
//   1. bias=0, 25x prod=65536 (1.0*1.0), out_ready=1 -> out_data=6400 (25.0), out_valid 1 cycle.
//   2. bias=0x0100, 25x prod=0 -> out_data=256; bias=0xFF00, 25x prod=0 -> -256 (0 with RELU_EN).
//   3. 25x prod=2^30 -> 32767; 25x prod=-2^30 -> -32768 (0 with RELU_EN).
//   4. rounding: prod=128 then 24x0 -> 1; prod=127 then 24x0 -> 0; prod=-129 then 24x0 -> -1.
//   5. out_ready low 5 cycles: out_valid/out_data stable, prod_ready=0, held prod not consumed;
//      random prod_valid bubbles within a window give same result as case 1.
//   6. rst after 10 taps, then case 1 -> 6400 (no residue); rst in HOLD -> out_valid=0 next cycle.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared CNN datapath definitions: default widths used by the multiplier
// array and the window accumulator, plus the accumulator FSM state type.
package cnn_pkg;

  localparam int CNN_SIZE        = 16;
  localparam int CNN_FRAC_BITS   = 8;
  localparam int CNN_KERNEL_TAPS = 25;
  localparam int CNN_ACC_W       = 40;
  // Tap counter width: covers the full legal kernel range 1..255.
  localparam int CNN_TAP_W       = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    ROUND = 2'd2,
    HOLD  = 2'd3
  } acc_state_t;

  // True in the states where a product may be taken from upstream.
  function automatic logic state_accepts(input acc_state_t st);
    logic ok_s;
    case (st)
      IDLE:    ok_s = 1'b1;
      ACCUM:   ok_s = 1'b1;
      default: ok_s = 1'b0;
    endcase
    return ok_s;
  endfunction

endpackage

// File: rtl/conv_window_accumulator_acc_round_sat.sv
// acc_round_sat: combinational round-half-up and saturation of a wide
// accumulator down to a SIZE-bit signed fixed-point result.
// Optional macro CONV_WINDOW_ACC_RELU_EN clamps negative results to zero.
module acc_round_sat
  import cnn_pkg::*;
#(
  parameter int ACC_W     = CNN_ACC_W,
  parameter int SIZE      = CNN_SIZE,
  parameter int FRAC_BITS = CNN_FRAC_BITS
) (
  input  logic [ACC_W-1:0] acc,
  output logic [SIZE-1:0]  res
);

  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-SIZE+1){1'b0}}, {(SIZE-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-SIZE+1){1'b1}}, {(SIZE-1){1'b0}}};

  logic signed [ACC_W-1:0] biased_s;
  logic signed [ACC_W-1:0] shifted_s;
  logic [SIZE-1:0]         sat_s;

  // Half-LSB rounding offset only exists when there are fractional bits to drop.
  if (FRAC_BITS > 0) begin : g_rnd
    localparam logic signed [ACC_W-1:0] HALF = {{(ACC_W-1){1'b0}}, 1'b1} <<< (FRAC_BITS-1);
    assign biased_s = $signed(acc) + HALF;
  end else begin : g_nornd
    assign biased_s = $signed(acc);
  end

  // Arithmetic shift floors, so with the half offset this rounds half toward +inf.
  assign shifted_s = biased_s >>> FRAC_BITS;

  // Clamp the rounded value into the signed SIZE-bit range.
  always_comb begin
    sat_s = shifted_s[SIZE-1:0];
    if (shifted_s > SAT_MAX) begin
      sat_s = SAT_MAX[SIZE-1:0];
    end else if (shifted_s < SAT_MIN) begin
      sat_s = SAT_MIN[SIZE-1:0];
    end else begin
      sat_s = shifted_s[SIZE-1:0];
    end
  end

  // Final activation stage: ReLU when enabled, otherwise pass-through.
  always_comb begin
    res = sat_s;
`ifdef CONV_WINDOW_ACC_RELU_EN
    if (sat_s[SIZE-1]) begin
      res = {SIZE{1'b0}};
    end else begin
      res = sat_s;
    end
`else
    res = sat_s;
`endif
  end

endmodule

// File: rtl/conv_window_accumulator.sv
// conv_window_accumulator: sums KERNEL_TAPS signed products plus a scaled
// per-filter bias, then rounds/saturates to SIZE bits and hands the result
// downstream with a valid/ready handshake.
// Optional macro CONV_WINDOW_ACC_RELU_EN (applied inside acc_round_sat).
module conv_window_accumulator
  import cnn_pkg::*;
#(
  parameter int SIZE        = CNN_SIZE,
  parameter int FRAC_BITS   = CNN_FRAC_BITS,
  parameter int KERNEL_TAPS = CNN_KERNEL_TAPS,
  parameter int ACC_W       = CNN_ACC_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [SIZE-1:0]   bias_i,
  input  logic [2*SIZE-1:0] prod_i,
  input  logic              prod_valid,
  output logic              prod_ready,
  output logic [SIZE-1:0]   out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy
);

  if (ACC_W < 2*SIZE + $clog2(KERNEL_TAPS) + 2) begin : g_acc_w_chk
    $error("conv_window_accumulator: ACC_W too small for SIZE/KERNEL_TAPS");
  end
  if (KERNEL_TAPS < 1 || KERNEL_TAPS > 255) begin : g_taps_chk
    $error("conv_window_accumulator: KERNEL_TAPS must be in 1..255");
  end

  localparam logic [CNN_TAP_W-1:0] LAST_CNT = CNN_TAP_W'(KERNEL_TAPS - 1);
  localparam logic [CNN_TAP_W-1:0] ONE_CNT  = {{(CNN_TAP_W-1){1'b0}}, 1'b1};

  acc_state_t             state_r;
  acc_state_t             state_next_s;
  logic [ACC_W-1:0]       acc_r;
  logic [CNN_TAP_W-1:0]   tap_cnt_r;
  logic                   prod_ready_r;
  logic                   busy_r;
  logic                   out_valid_r;
  logic [SIZE-1:0]        out_data_r;
  logic [SIZE-1:0]        rs_result_s;
  logic                   accept_s;
  logic [ACC_W-1:0]       bias_ext_s;
  logic [ACC_W-1:0]       prod_ext_s;

  assign accept_s   = prod_valid & prod_ready_r;
  // Bias is in operand format; align it with the product's 2*FRAC_BITS scale.
  assign bias_ext_s = {{(ACC_W-SIZE){bias_i[SIZE-1]}}, bias_i} <<< FRAC_BITS;
  assign prod_ext_s = {{(ACC_W-2*SIZE){prod_i[2*SIZE-1]}}, prod_i};

  assign prod_ready = prod_ready_r;
  assign busy       = busy_r;
  assign out_valid  = out_valid_r;
  assign out_data   = out_data_r;

  acc_round_sat #(
    .ACC_W    (ACC_W),
    .SIZE     (SIZE),
    .FRAC_BITS(FRAC_BITS)
  ) u_round_sat (
    .acc(acc_r),
    .res(rs_result_s)
  );

  // Window sequencing: collect taps, round once, hold until downstream takes it.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_next_s = (KERNEL_TAPS == 1) ? ROUND : ACCUM;
        end else begin
          state_next_s = IDLE;
        end
      end
      ACCUM: begin
        if (accept_s && (tap_cnt_r == LAST_CNT)) begin
          state_next_s = ROUND;
        end else begin
          state_next_s = ACCUM;
        end
      end
      ROUND: state_next_s = HOLD;
      HOLD: begin
        if (out_ready) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = HOLD;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Registered ready/busy flags, derived from the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      prod_ready_r <= 1'b1;
      busy_r       <= 1'b0;
    end else begin
      prod_ready_r <= state_accepts(state_next_s);
      busy_r       <= (state_next_s != IDLE);
    end
  end

  // Accumulator and tap counter: the first tap of a window restarts the sum with the bias.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_r     <= {ACC_W{1'b0}};
      tap_cnt_r <= {CNN_TAP_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            acc_r     <= bias_ext_s + prod_ext_s;
            tap_cnt_r <= ONE_CNT;
          end
        end
        ACCUM: begin
          if (accept_s) begin
            acc_r     <= acc_r + prod_ext_s;
            tap_cnt_r <= tap_cnt_r + ONE_CNT;
          end
        end
        default: begin
          acc_r     <= acc_r;
          tap_cnt_r <= tap_cnt_r;
        end
      endcase
    end
  end

  // Output register: capture the rounded result once, hold it until the handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_r  <= {SIZE{1'b0}};
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        ROUND: begin
          out_data_r  <= rs_result_s;
          out_valid_r <= 1'b1;
        end
        HOLD: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv_window_accumulator.sv
// Self-checking bench for conv_window_accumulator (SIZE=16, FRAC_BITS=8, 25 taps).
module tb_conv_window_accumulator;

  localparam int TAPS = 25;

`ifdef CONV_WINDOW_ACC_RELU_EN
  localparam logic [15:0] EXP_NEG256 = 16'd0;
  localparam logic [15:0] EXP_NEGMAX = 16'd0;
  localparam logic [15:0] EXP_NEG1   = 16'd0;
`else
  localparam logic [15:0] EXP_NEG256 = 16'hFF00;
  localparam logic [15:0] EXP_NEGMAX = 16'h8000;
  localparam logic [15:0] EXP_NEG1   = 16'hFFFF;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] bias_i;
  logic [31:0] prod_i;
  logic        prod_valid;
  logic        prod_ready;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        busy;

  int checks = 0;
  int errors = 0;

  logic [31:0] taps [TAPS];

  typedef struct {
    logic [15:0] bias;
    logic [31:0] p0;
    logic [31:0] prest;
    logic [15:0] exp;
    string       name;
  } vec_t;

  vec_t vecs [8];

  conv_window_accumulator dut (
    .clk       (clk),
    .rst       (rst),
    .bias_i    (bias_i),
    .prod_i    (prod_i),
    .prod_valid(prod_valid),
    .prod_ready(prod_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (got timeout, expected completion)");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_taps(input logic [31:0] p0, input logic [31:0] prest);
    for (int i = 0; i < TAPS; i++) taps[i] = (i == 0) ? p0 : prest;
  endtask

  // Reference: exact window sum with plain 64-bit arithmetic, then round/clamp.
  function automatic logic [15:0] model(input logic [15:0] b);
    longint s;
    longint r;
    s = longint'($signed(b)) * 256;
    for (int i = 0; i < TAPS; i++) s += longint'($signed(taps[i]));
    r = (s + 128) >>> 8;
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
`ifdef CONV_WINDOW_ACC_RELU_EN
    if (r < 0) r = 0;
`endif
    return 16'(r);
  endfunction

  // Present one tap and wait (bounded) until it is accepted.
  task automatic send_tap(input logic [15:0] b, input logic [31:0] p);
    bit took;
    took = 1'b0;
    bias_i = b;
    prod_i = p;
    prod_valid = 1'b1;
    for (int n = 0; n < 50 && !took; n++) begin
      took = prod_ready;
      tick();
    end
    if (!took) chk("tap_accept_timeout", 32'd0, 32'd1);
    prod_valid = 1'b0;
  endtask

  // Feed a whole window from taps[], wait for the result, handshake if out_ready.
  task automatic run_window(input logic [15:0] b, input bit bubbles,
                            output logic [15:0] got, output int lat);
    for (int i = 0; i < TAPS; i++) begin
      if (bubbles && $urandom_range(0, 2) == 0) begin
        prod_valid = 1'b0;
        repeat ($urandom_range(1, 2)) tick();
      end
      send_tap((i == 0) ? b : 16'($urandom), taps[i]);
      if (i == 0) chk("busy_in_window", {31'd0, busy}, 32'd1);
    end
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    got = out_data;
    if (out_ready) begin
      tick();
      chk("out_valid_one_cycle", {31'd0, out_valid}, 32'd0);
    end
  endtask

  initial begin
    logic [15:0] got;
    int          lat;
    logic [15:0] b;
    logic [15:0] exp;

    rst = 1'b1;
    prod_valid = 1'b0;
    bias_i = 16'd0;
    prod_i = 32'd0;
    out_ready = 1'b1;
    repeat (2) tick();
    chk("rst_out_valid",  {31'd0, out_valid}, 32'd0);
    chk("rst_out_data",   {16'd0, out_data}, 32'd0);
    chk("rst_busy",       {31'd0, busy}, 32'd0);
    chk("rst_prod_ready", {31'd0, prod_ready}, 32'd1);
    rst = 1'b0;

    vecs[0] = '{16'h0000, 32'd65536,      32'd65536,      16'd6400,   "ones_6400"};
    vecs[1] = '{16'h0100, 32'd0,          32'd0,          16'd256,    "bias_pos"};
    vecs[2] = '{16'hFF00, 32'd0,          32'd0,          EXP_NEG256, "bias_neg"};
    vecs[3] = '{16'h0000, 32'h4000_0000,  32'h4000_0000,  16'd32767,  "sat_pos"};
    vecs[4] = '{16'h0000, 32'hC000_0000,  32'hC000_0000,  EXP_NEGMAX, "sat_neg"};
    vecs[5] = '{16'h0000, 32'd128,        32'd0,          16'd1,      "round_half_up"};
    vecs[6] = '{16'h0000, 32'd127,        32'd0,          16'd0,      "round_below_half"};
    vecs[7] = '{16'h0000, 32'hFFFF_FF7F,  32'd0,          EXP_NEG1,   "round_neg"};

    foreach (vecs[k]) begin
      set_taps(vecs[k].p0, vecs[k].prest);
      run_window(vecs[k].bias, 1'b0, got, lat);
      chk(vecs[k].name, {16'd0, got}, {16'd0, vecs[k].exp});
      chk("latency", 32'(lat), 32'd1);
    end

    // Bubbles inside a window do not change the result.
    set_taps(32'd65536, 32'd65536);
    run_window(16'h0000, 1'b1, got, lat);
    chk("bubbles_6400", {16'd0, got}, 32'd6400);

    // Downstream stall: output frozen, upstream product held but not consumed.
    out_ready = 1'b0;
    set_taps(32'd65536, 32'd65536);
    run_window(16'h0000, 1'b0, got, lat);
    chk("stall_result", {16'd0, got}, 32'd6400);
    bias_i = 16'h0000;
    prod_i = 32'd128;
    prod_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("stall_out_valid",  {31'd0, out_valid}, 32'd1);
      chk("stall_out_data",   {16'd0, out_data}, 32'd6400);
      chk("stall_prod_ready", {31'd0, prod_ready}, 32'd0);
    end
    out_ready = 1'b1;
    tick();
    chk("stall_release", {31'd0, out_valid}, 32'd0);
    set_taps(32'd128, 32'd0);
    run_window(16'h0000, 1'b0, got, lat);
    chk("held_tap_not_consumed", {16'd0, got}, 32'd1);

    // Reset mid-window discards the partial sum.
    for (int k = 0; k < 10; k++) send_tap(16'h0000, 32'd65536);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_busy",       {31'd0, busy}, 32'd0);
    chk("midrst_prod_ready", {31'd0, prod_ready}, 32'd1);
    set_taps(32'd65536, 32'd65536);
    run_window(16'h0000, 1'b0, got, lat);
    chk("after_midrst_6400", {16'd0, got}, 32'd6400);

    // Reset while holding a result drops it.
    out_ready = 1'b0;
    run_window(16'h0000, 1'b0, got, lat);
    chk("hold_before_rst", {31'd0, out_valid}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_in_hold_valid", {31'd0, out_valid}, 32'd0);
    out_ready = 1'b1;
    tick();

    // Randomized windows against the arithmetic model.
    for (int w = 0; w < 30; w++) begin
      b = 16'($urandom);
      for (int i = 0; i < TAPS; i++) begin
        if (w % 3 == 0) taps[i] = $urandom;
        else taps[i] = 32'($urandom_range(0, 262143)) - 32'd131072;
      end
      exp = model(b);
      run_window(b, 1'b1, got, lat);
      chk("random_window", {16'd0, got}, {16'd0, exp});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
